checkpoint_seq_monitor: RTL
===========================

Name: checkpoint_seq_monitor

Overview:
- Synthesisable successor to the bench-side checkbits monitor used by the firmware LA/matmul tests.
- Watches a GPIO checkpoint bus, such as mprj_io[31:16], for a programmable, ordered sequence of expected values.
- Filters glitches with a stability qualifier and enforces a per-checkpoint timeout.
- Reports progress, pass, fail and timeout as registered flags, so the same logic can sit in a bench, a user-project wrapper or an FPGA harness.

Parameters:
- DATA_W, 16: checkpoint bus width.
- DEPTH, 8: number of expected-value slots (≥2). AW = $clog2(DEPTH), LW = $clog2(DEPTH+1).
- TIMEOUT_W, 20: width of the per-checkpoint cycle counter.
- STABLE_CYC, 2: consecutive equal synchronised samples (≥1) needed to qualify a value.

Ports:
- wb_clk_i  in  1  sole clock; all logic on rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- cfg_we  in  1  write exp[cfg_addr] <= cfg_data; ignored while busy.
- cfg_addr  in  AW  expected-slot index.
- cfg_data  in  DATA_W  expected value.
- cfg_len  in  LW  sequence length 0..DEPTH; sampled on start.
- cfg_strict  in  1  strict mode; sampled on start.
- timeout_limit  in  TIMEOUT_W  per-checkpoint limit, 0 = disabled; sampled on start.
- start  in  1  arm a run.
- abort  in  1  cancel; return to IDLE.
- checkbits_i  in  DATA_W  asynchronous checkpoint bus.
- busy  out  1  run in progress.
- pass  out  1  sticky: full sequence matched.
- fail  out  1  sticky: run failed (mismatch or timeout).
- timeout  out  1  sticky: failure cause was a timeout.
- match_pulse  out  1  one-cycle pulse per matched checkpoint.
- match_idx  out  LW  number of checkpoints matched so far.
- elapsed  out  TIMEOUT_W  cycles since arm or last match; saturates.

Behaviour:
- Reset
  - State IDLE. All outputs 0. Internal latched cfg values 0. Sync and stability registers 0.
  - exp[] memory is not reset.
- Input path
  - 2-flop synchroniser s1 -> s2.
  - run_len = 1 on the first cycle s2 differs from its previous value; otherwise it increments, saturating at STABLE_CYC.
  - qual pulses for one cycle when run_len reaches STABLE_CYC, i.e. once per stable value run.
  - If checkbits_i changes at edge t and then holds, qual fires in cycle t+1+STABLE_CYC and match_pulse is registered at t+2+STABLE_CYC (t+4 at defaults).
- States: IDLE, ARMED, PASS, FAIL.
  - IDLE/PASS/FAIL -> start -> ARMED. On this transition: latch cfg_len, cfg_strict, timeout_limit; clear idx, elapsed, pass, fail, timeout; set busy.
  - If latched len == 0, go from ARMED to PASS on the next cycle.
- ARMED, each cycle
  - qual and s2 == exp[idx]: match_pulse=1, idx++, elapsed=0.
    - If idx+1 == len: -> PASS (pass=1, busy=0).
  - qual, s2 != exp[idx], cfg_strict=1, and s2 != exp[idx-1] (idx>0; at idx 0 any non-match is ignored): -> FAIL (fail=1, busy=0).
  - cfg_strict=0: non-matching values are ignored (wait semantics).
  - Otherwise elapsed++ (saturating). If limit != 0 and elapsed+1 == limit: -> FAIL with timeout=1.
  - Match and timeout in the same cycle: the match wins.
- Priority: wb_rst_i > abort > start.
  - abort in any state: -> IDLE, all flags cleared, busy=0.
  - start while ARMED is ignored.
- PASS/FAIL hold their flags until start, abort or reset.
- A reset mid-run returns to IDLE within one cycle with no pulse.

Test Plan:
1. Load exp = {AB40, 003E, 0044, 004A, 0050, AB51}, len=6, limit=1000, strict=0. Drive the sequence, each value held for 10 cycles. -> 6 match_pulses, match_idx 1..6, pass=1 4 cycles after AB51 appears, busy=0.
2. Same sequence with a 1-cycle glitch 0xFFFF between 003E and 0044. -> glitch not qualified, pass=1, no fail.
3. strict=1. Drive AB40, 003E, then hold 1234 for 5 cycles. -> fail=1, timeout=0, match_idx=2. With strict=0 the same stimulus leaves the run ARMED.
4. limit=50. Drive AB40, then hold it. -> match_idx=1; fail=1 and timeout=1 exactly 50 cycles after the match; elapsed=49.
5. len=0 then start. -> pass=1 one cycle later. Assert start and abort together while ARMED. -> IDLE, all flags 0.
6. wb_rst_i pulsed after 3 matches. -> outputs all 0 next cycle. A cfg_we issued while busy leaves exp[] unchanged, verified by a second run.

Source files
------------

// File: rtl/checkpoint_seq_monitor.sv
// checkpoint_seq_monitor: watches a GPIO checkpoint bus for a programmed,
// ordered sequence of values, with a glitch filter and a per-step timeout.
module checkpoint_seq_monitor #(
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 8,
  parameter int TIMEOUT_W  = 20,
  parameter int STABLE_CYC = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 cfg_we,
  input  logic [AW-1:0]        cfg_addr,
  input  logic [DATA_W-1:0]    cfg_data,
  input  logic [LW-1:0]        cfg_len,
  input  logic                 cfg_strict,
  input  logic [TIMEOUT_W-1:0] timeout_limit,
  input  logic                 start,
  input  logic                 abort,
  input  logic [DATA_W-1:0]    checkbits_i,
  output logic                 busy,
  output logic                 pass,
  output logic                 fail,
  output logic                 timeout,
  output logic                 match_pulse,
  output logic [LW-1:0]        match_idx,
  output logic [TIMEOUT_W-1:0] elapsed
);

  localparam int RW = (STABLE_CYC < 2) ? 1 : $clog2(STABLE_CYC + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_PASS,
    ST_FAIL
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0]    s1, s2, held;
  logic [RW-1:0]        run_len, run_nxt;
  logic                 differ, qual, qual_nxt;
  logic [DATA_W-1:0]    exp_mem [DEPTH];
  logic [LW-1:0]        len_q, idx;
  logic [LW-1:0]        idx_m1, idx_p1;
  logic                 strict_q;
  logic [TIMEOUT_W-1:0] limit_q, elapsed_q;
  logic                 timeout_q, match_q;
  logic [DATA_W-1:0]    exp_cur, exp_prev;
  logic                 hit, last, bad, tmo;
  logic                 armed_run;

  // held is the value whose run length run_len is counting
  always_comb begin
    differ  = (s2 != held);
    run_nxt = run_len;
    if (differ)
      run_nxt = RW'(1);
    else if (run_len < RW'(STABLE_CYC))
      run_nxt = run_len + RW'(1);
    qual_nxt = (run_nxt == RW'(STABLE_CYC))
             && (differ || run_len != RW'(STABLE_CYC));
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      s1      <= '0;
      s2      <= '0;
      held    <= '0;
      run_len <= '0;
      qual    <= 1'b0;
    end else begin
      s1      <= checkbits_i;
      s2      <= s1;
      held    <= s2;
      run_len <= run_nxt;
      qual    <= qual_nxt;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (cfg_we && state != ST_ARMED)
      exp_mem[cfg_addr] <= cfg_data;
  end

  always_comb begin
    idx_m1    = idx - LW'(1);
    idx_p1    = idx + LW'(1);
    exp_cur   = exp_mem[idx[AW-1:0]];
    exp_prev  = exp_mem[idx_m1[AW-1:0]];
    armed_run = (state == ST_ARMED) && (len_q != '0);
    hit       = armed_run && qual && (held == exp_cur);
    last      = (idx_p1 == len_q);
    bad       = armed_run && qual && !hit && strict_q
              && (idx != '0) && (held != exp_prev);
    tmo       = armed_run && (limit_q != '0)
              && (({1'b0, elapsed_q} + (TIMEOUT_W+1)'(1))
                  == {1'b0, limit_q});
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE, ST_PASS, ST_FAIL: begin
          if (start)
            state_nxt = ST_ARMED;
        end
        ST_ARMED: begin
          if (len_q == '0)
            state_nxt = ST_PASS;
          else if (hit && last)
            state_nxt = ST_PASS;
          else if (hit)
            state_nxt = ST_ARMED;
          else if (bad || tmo)
            state_nxt = ST_FAIL;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // a match beats a timeout landing on the same cycle
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      len_q     <= '0;
      strict_q  <= 1'b0;
      limit_q   <= '0;
      idx       <= '0;
      elapsed_q <= '0;
      timeout_q <= 1'b0;
      match_q   <= 1'b0;
    end else begin
      match_q <= 1'b0;
      if (abort) begin
        idx       <= '0;
        elapsed_q <= '0;
        timeout_q <= 1'b0;
      end else if (start && state != ST_ARMED) begin
        len_q     <= (cfg_len > LW'(DEPTH)) ? LW'(DEPTH) : cfg_len;
        strict_q  <= cfg_strict;
        limit_q   <= timeout_limit;
        idx       <= '0;
        elapsed_q <= '0;
        timeout_q <= 1'b0;
      end else if (armed_run) begin
        if (hit) begin
          match_q   <= 1'b1;
          idx       <= idx_p1;
          elapsed_q <= '0;
        end else if (bad) begin
          elapsed_q <= elapsed_q;
        end else if (tmo) begin
          timeout_q <= 1'b1;
        end else if (elapsed_q != '1) begin
          elapsed_q <= elapsed_q + TIMEOUT_W'(1);
        end
      end
    end
  end

  always_comb begin
    busy        = (state == ST_ARMED);
    pass        = (state == ST_PASS);
    fail        = (state == ST_FAIL);
    timeout     = timeout_q;
    match_pulse = match_q;
    match_idx   = idx;
    elapsed     = elapsed_q;
  end

endmodule
